// File: rtl/read_controller_sdram_pkg.sv
// Shared constants for the SDRAM frame-buffer read and write controllers:
// default frame geometry, FSM state encodings and the frame-size helper.
package read_controller_sdram_pkg;

   // Default frame geometry and SDRAM burst shape used by both controllers
   localparam int unsigned DEF_FRAME_WIDTH  = 640;
   localparam int unsigned DEF_FRAME_HEIGHT = 480;
   localparam int unsigned DEF_BURST_LEN    = 8;
   localparam int unsigned DEF_PIXEL_W      = 16;
   localparam int unsigned DEF_SDRAM_ADDR_W = 24;

   // Words in one frame; address and pixel counters wrap at this value
   function automatic int unsigned frame_words(input int unsigned width,
                                               input int unsigned height);
      return width * height;
   endfunction

   localparam int unsigned FrameWords = frame_words(DEF_FRAME_WIDTH, DEF_FRAME_HEIGHT);

   // Read-side burst FSM
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      BURST_REQ  = 2'd1,
      BURST_READ = 2'd2,
      BURST_DONE = 2'd3
   } rd_state_e;

   // Write-side burst FSM
   typedef enum logic [1:0] {
      WR_IDLE        = 2'd0,
      WR_BURST_REQ   = 2'd1,
      WR_BURST_WRITE = 2'd2,
      WR_BURST_DONE  = 2'd3
   } wr_state_e;

endpackage

// File: rtl/read_controller_sdram_fifo.sv
// Synchronous first-word-fall-through FIFO holding pixels between the SDRAM
// read bursts and the display consumer. Depth must be a power of two.
module pixel_fifo_sync #(
   parameter int unsigned Depth = 16,
   parameter int unsigned Width = 16,
   localparam int unsigned PtrW = $clog2(Depth),
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [Width-1:0] data_i,
   output logic [Width-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CntW-1:0]  count_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             wr_en, rd_en;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign wr_en   = push_i && !full_o;
   assign rd_en   = pop_i && !empty_o;

   // Head word is presented directly; forced to zero while empty so the
   // output is clean after reset without clearing the storage array
   assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

   // Pointer and occupancy update; push and pop in one cycle cancel out
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (wr_en && !rd_en) count_d = count_q + CntW'(1);
      if (rd_en && !wr_en) count_d = count_q - CntW'(1);
   end

   // Control state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array write port
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/read_controller_sdram.sv
// Frame-buffer read controller: fetches fixed-length SDRAM read bursts in
// frame order into a two-burst pixel FIFO and streams them to the display.
module read_controller_sdram
   import read_controller_sdram_pkg::*;
#(
   parameter int unsigned FrameWidth        = DEF_FRAME_WIDTH,
   parameter int unsigned FrameHeight       = DEF_FRAME_HEIGHT,
   parameter int unsigned BurstLengthSDRAM  = DEF_BURST_LEN,
   parameter int unsigned PixelBitWidth     = DEF_PIXEL_W,
   parameter int unsigned AddressWidthSDRAM = DEF_SDRAM_ADDR_W
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         i_sdram_ack,
   input  logic                         i_sdram_valid_rd,
   input  logic [PixelBitWidth-1:0]     i_sdram_data,
   input  logic                         i_pixel_req,
   output logic                         o_sdram_rd_req,
   output logic [AddressWidthSDRAM-1:0] o_sdram_addr,
   output logic [PixelBitWidth-1:0]     o_pixel,
   output logic                         o_pixel_valid,
   output logic                         o_sof,
   output logic                         o_busy_rd
);

   localparam int unsigned FrameWordsP = frame_words(FrameWidth, FrameHeight);
   localparam int unsigned AddrW       = $clog2(FrameWordsP + 1);
   localparam int unsigned Depth       = 2 * BurstLengthSDRAM;
   localparam int unsigned CntW        = $clog2(Depth + 1);
   localparam int unsigned BeatW       = $clog2(BurstLengthSDRAM);

   rd_state_e                    state_q, state_d;
   logic [AddrW-1:0]             head_q, head_d;
   logic [AddrW-1:0]             pix_q, pix_d;
   logic [BeatW-1:0]             beat_q, beat_d;
   logic                         rd_req_q, rd_req_d;
   logic [AddressWidthSDRAM-1:0] addr_q, addr_d;
   logic                         busy_q;

   logic                         fifo_full, fifo_empty;
   logic [CntW-1:0]              fifo_count;
   logic [PixelBitWidth-1:0]     fifo_data;
   logic                         push, pop;
   logic [CntW:0]                free_w;
   logic                         burst_room;
   logic                         last_beat;

   assign pop       = i_pixel_req && !fifo_empty;
   assign push      = (state_q == BURST_READ) && i_sdram_valid_rd && !fifo_full;
   assign last_beat = (beat_q == BeatW'(BurstLengthSDRAM - 1));

   // Free space counts a pop happening this cycle, so a steadily draining
   // consumer lets the next burst start one cycle earlier
   assign free_w     = (CntW + 1)'(Depth) - {1'b0, fifo_count} + {{CntW{1'b0}}, pop};
   assign burst_room = (free_w >= (CntW + 1)'(BurstLengthSDRAM));

   pixel_fifo_sync #(
      .Depth (Depth),
      .Width (PixelBitWidth)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (i_sdram_data),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // FSM state register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:       if (burst_room) state_d = BURST_REQ;
         BURST_REQ:  if (i_sdram_ack) state_d = BURST_READ;
         BURST_READ: if (i_sdram_valid_rd && last_beat) state_d = BURST_DONE;
         BURST_DONE: state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // FSM outputs and burst bookkeeping; request and address are registered
   // on entry to BURST_REQ so they are stable for the whole handshake
   always_comb begin
      rd_req_d = rd_req_q;
      addr_d   = addr_q;
      head_d   = head_q;
      beat_d   = beat_q;
      unique case (state_q)
         IDLE: begin
            if (burst_room) begin
               rd_req_d = 1'b1;
               addr_d   = AddressWidthSDRAM'(head_q);
            end
         end
         BURST_REQ: begin
            if (i_sdram_ack) begin
               rd_req_d = 1'b0;
               head_d   = head_q + AddrW'(BurstLengthSDRAM);
               beat_d   = '0;
            end
         end
         BURST_READ: begin
            if (i_sdram_valid_rd) beat_d = beat_q + BeatW'(1);
         end
         BURST_DONE: begin
            if (head_q == AddrW'(FrameWordsP)) head_d = '0;
         end
         default: ;
      endcase
   end

   // Output pixel counter: position of the FIFO head within the frame
   always_comb begin
      pix_d = pix_q;
      if (pop) pix_d = (pix_q == AddrW'(FrameWordsP - 1)) ? '0 : pix_q + AddrW'(1);
   end

   // Datapath and output registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         head_q   <= '0;
         pix_q    <= '0;
         beat_q   <= '0;
         rd_req_q <= 1'b0;
         addr_q   <= '0;
         busy_q   <= 1'b0;
      end else begin
         head_q   <= head_d;
         pix_q    <= pix_d;
         beat_q   <= beat_d;
         rd_req_q <= rd_req_d;
         addr_q   <= addr_d;
         busy_q   <= (state_q != IDLE);
      end
   end

   assign o_sdram_rd_req = rd_req_q;
   assign o_sdram_addr   = addr_q;
   assign o_pixel        = fifo_data;
   assign o_pixel_valid  = !fifo_empty;
   assign o_sof          = (pix_q == '0) && !fifo_empty;
   assign o_busy_rd      = busy_q;

endmodule

// File: tb/tb_read_controller_sdram.sv
// Bench for read_controller_sdram: an SDRAM responder serves burst requests
// with random ack delays, beat gaps and data; a monitor compares every FIFO
// head against a queue of expected pixels tagged with their frame position.
module tb_read_controller_sdram;

   localparam int FW     = 4;
   localparam int FH     = 2;
   localparam int BL     = 4;
   localparam int PW     = 16;
   localparam int ASW    = 24;
   localparam int FWORDS = FW * FH;

   logic           CLK = 1'b0;
   logic           RST = 1'b1;
   logic           i_sdram_ack = 1'b0;
   logic           i_sdram_valid_rd = 1'b0;
   logic [PW-1:0]  i_sdram_data = '0;
   logic           i_pixel_req = 1'b0;
   logic           o_sdram_rd_req;
   logic [ASW-1:0] o_sdram_addr;
   logic [PW-1:0]  o_pixel;
   logic           o_pixel_valid;
   logic           o_sof;
   logic           o_busy_rd;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [PW-1:0] exp_pix_q[$];
   bit            exp_sof_q[$];
   int            exp_addr = 0;
   int            pop_mode = 0;
   bit            mon_en   = 1'b0;

   always #5 CLK = ~CLK;

   read_controller_sdram #(
      .FrameWidth        (FW),
      .FrameHeight       (FH),
      .BurstLengthSDRAM  (BL),
      .PixelBitWidth     (PW),
      .AddressWidthSDRAM (ASW)
   ) dut (
      .CLK              (CLK),
      .RST              (RST),
      .i_sdram_ack      (i_sdram_ack),
      .i_sdram_valid_rd (i_sdram_valid_rd),
      .i_sdram_data     (i_sdram_data),
      .i_pixel_req      (i_pixel_req),
      .o_sdram_rd_req   (o_sdram_rd_req),
      .o_sdram_addr     (o_sdram_addr),
      .o_pixel          (o_pixel),
      .o_pixel_valid    (o_pixel_valid),
      .o_sof            (o_sof),
      .o_busy_rd        (o_busy_rd)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Consumer: never / always / randomly requests a pixel each cycle
   initial forever begin
      @(posedge CLK);
      #1;
      case (pop_mode)
         0:       i_pixel_req = 1'b0;
         1:       i_pixel_req = 1'b1;
         default: i_pixel_req = ($urandom_range(1, 0) == 1);
      endcase
   end

   // Monitor: FIFO head must match the oldest outstanding expected pixel
   always @(negedge CLK) begin
      if (mon_en && RST) begin
         check("pixel_valid", 32'(o_pixel_valid), 32'(exp_pix_q.size() != 0));
         if (exp_pix_q.size() != 0) begin
            check("pixel_data", 32'(o_pixel), 32'(exp_pix_q[0]));
            check("sof", 32'(o_sof), 32'(exp_sof_q[0]));
            if (i_pixel_req) begin
               exp_pix_q.delete(0);
               exp_sof_q.delete(0);
            end
         end else begin
            check("sof_when_empty", 32'(o_sof), 32'd0);
         end
      end
   end

   // SDRAM responder for one burst; nbeats < BL leaves the burst unfinished
   task automatic serve(input int ack_dly, input int max_gap, input bit use_a0, input int nbeats);
      int             n;
      int             gap;
      logic [ASW-1:0] a0;
      logic [PW-1:0]  d;
      n = 0;
      @(negedge CLK);
      while (!o_sdram_rd_req && n < 300) begin
         @(negedge CLK);
         n++;
      end
      if (!o_sdram_rd_req) begin
         check("rd_req_timeout", 32'(o_sdram_rd_req), 32'd1);
         return;
      end
      check("req_addr", 32'(o_sdram_addr), 32'(exp_addr));
      a0 = o_sdram_addr;
      for (int i = 0; i < ack_dly; i++) begin
         @(negedge CLK);
         check("req_hold", 32'(o_sdram_rd_req), 32'd1);
         check("addr_hold", 32'(o_sdram_addr), 32'(a0));
      end
      i_sdram_ack = 1'b1;
      @(posedge CLK);
      #1 i_sdram_ack = 1'b0;
      @(negedge CLK);
      check("req_drop", 32'(o_sdram_rd_req), 32'd0);
      check("busy_in_burst", 32'(o_busy_rd), 32'd1);
      for (int b = 0; b < nbeats; b++) begin
         gap = $urandom_range(max_gap, 0);
         repeat (gap) @(negedge CLK);
         d = use_a0 ? PW'(16'hA0 + b) : PW'($urandom);
         i_sdram_valid_rd = 1'b1;
         i_sdram_data     = d;
         @(posedge CLK);
         exp_pix_q.push_back(d);
         exp_sof_q.push_back(((exp_addr + b) % FWORDS) == 0);
         #1 i_sdram_valid_rd = 1'b0;
      end
      if (nbeats == BL) exp_addr = (exp_addr + BL) % FWORDS;
   endtask

   // Time bound in case the design stops responding altogether
   initial begin
      #400000;
      $display("FAIL watchdog: got no completion, expected finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      #3 RST = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_rd_req", 32'(o_sdram_rd_req), 32'd0);
      check("rst_addr", 32'(o_sdram_addr), 32'd0);
      check("rst_pixel", 32'(o_pixel), 32'd0);
      check("rst_valid", 32'(o_pixel_valid), 32'd0);
      check("rst_sof", 32'(o_sof), 32'd0);
      check("rst_busy", 32'(o_busy_rd), 32'd0);
      @(negedge CLK);
      RST    = 1'b1;
      mon_en = 1'b1;

      // Fill without consuming: two bursts, then the FIFO is full
      pop_mode = 0;
      serve(0, 0, 1'b1, BL);
      serve(5, 1, 1'b0, BL);
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK);
         check("no_third_req", 32'(o_sdram_rd_req), 32'd0);
      end
      check("busy_idle_full", 32'(o_busy_rd), 32'd0);

      // Continuous consumption across frame wrap
      pop_mode = 1;
      repeat (4) serve($urandom_range(3, 0), 2, 1'b0, BL);

      // Random consumption, random handshakes
      pop_mode = 2;
      repeat (8) serve($urandom_range(5, 0), 3, 1'b0, BL);

      // Reset in the middle of a burst after two beats
      pop_mode = 1;
      serve($urandom_range(2, 0), 1, 1'b0, 2);
      mon_en = 1'b0;
      #2 RST = 1'b0;
      #1;
      check("mid_rst_rd_req", 32'(o_sdram_rd_req), 32'd0);
      check("mid_rst_addr", 32'(o_sdram_addr), 32'd0);
      check("mid_rst_pixel", 32'(o_pixel), 32'd0);
      check("mid_rst_valid", 32'(o_pixel_valid), 32'd0);
      check("mid_rst_sof", 32'(o_sof), 32'd0);
      check("mid_rst_busy", 32'(o_busy_rd), 32'd0);
      exp_pix_q.delete();
      exp_sof_q.delete();
      exp_addr = 0;
      i_sdram_valid_rd = 1'b1;
      i_sdram_data     = 16'hDEAD;
      @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1 i_sdram_valid_rd = 1'b0;
      mon_en = 1'b1;

      // Requests while empty must not advance the frame position
      serve(1, 2, 1'b0, BL);
      serve(0, 2, 1'b0, BL);

      // Drain remaining pixels
      for (int i = 0; i < 100 && exp_pix_q.size() != 0; i++) @(negedge CLK);
      check("drain", 32'(exp_pix_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/read_controller_sdram.md
READ_CONTROLLER_SDRAM -- requirements
Module: read_controller_sdram

Interface
REQ-001 SHALL have parameter FrameWidth, default 640, active pixels per line.
REQ-002 SHALL have parameter FrameHeight, default 480, lines per frame.
REQ-003 SHALL have parameter BurstLengthSDRAM, default 8, words per SDRAM read burst (power of 2, >=2).
REQ-004 SHALL have parameter PixelBitWidth, default 16, pixel/data word width.
REQ-005 SHALL have parameter AddressWidthSDRAM, default 24, SDRAM word address width.
REQ-006 SHALL have port CLK  input  1  single clock, rising edge.
REQ-007 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port i_sdram_ack  input  1  SDRAM controller accepted current burst request.
REQ-009 SHALL have port i_sdram_valid_rd  input  1  read data beat valid on i_sdram_data.
REQ-010 SHALL have port i_sdram_data  input  PixelBitWidth  read data beat.
REQ-011 SHALL have port i_pixel_req  input  1  consumer (VGA side) takes o_pixel this cycle.
REQ-012 SHALL have port o_sdram_rd_req  output  1  burst read request.
REQ-013 SHALL have port o_sdram_addr  output  AddressWidthSDRAM  burst start word address.
REQ-014 SHALL have port o_pixel  output  PixelBitWidth  head-of-buffer pixel.
REQ-015 SHALL have port o_pixel_valid  output  1  o_pixel holds valid data.
REQ-016 SHALL have port o_sof  output  1  o_pixel is frame pixel 0 (qualified by o_pixel_valid).
REQ-017 SHALL have port o_busy_rd  output  1  registered; high one cycle after state leaves IDLE, low one cycle after it returns.

Function
REQ-018 SHALL buffer pixels in a FIFO of depth 2*BurstLengthSDRAM; o_pixel/o_pixel_valid driven from FIFO head (first-word-fall-through); o_pixel_valid = FIFO not empty.
REQ-019 SHALL pop one pixel when i_pixel_req && o_pixel_valid; i_pixel_req while empty is ignored (no pop, no counter change).
REQ-020 SHALL use states IDLE, BURST_REQ, BURST_READ, BURST_DONE.
REQ-021 IDLE -> BURST_REQ when FIFO free entries (depth minus occupancy, counting the same-cycle pop) >= BurstLengthSDRAM.
REQ-022 BURST_REQ: o_sdram_rd_req=1 and o_sdram_addr=HeadAddress held stable until i_sdram_ack; on ack: rd_req<=0, HeadAddress += BurstLengthSDRAM, beat counter<=0, -> BURST_READ.
REQ-023 BURST_READ: each i_sdram_valid_rd pushes i_sdram_data, beat counter +1; after beat BurstLengthSDRAM-1 -> BURST_DONE.
REQ-024 BURST_DONE: one cycle; if HeadAddress == FrameWidth*FrameHeight, HeadAddress<=0; -> IDLE.
REQ-025 i_sdram_valid_rd outside BURST_READ SHALL be ignored; FIFO never overflows (guaranteed by REQ-021).
REQ-026 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-027 Output pixel counter SHALL increment per pop, wrap to 0 after FrameWidth*FrameHeight-1; o_sof = (counter==0) && o_pixel_valid.
REQ-028 FrameWidth*FrameHeight SHALL be a multiple of BurstLengthSDRAM; address and pixel counter SHALL wrap in lockstep.
REQ-029 Address arithmetic SHALL use $clog2(FrameWidth*FrameHeight+1) bits, zero-extended to o_sdram_addr.

Reset
REQ-030 On RST low (async): state IDLE, HeadAddress 0, beat/pixel counters 0, FIFO empty, o_sdram_rd_req 0, o_sdram_addr 0, o_pixel 0, o_pixel_valid 0, o_sof 0, o_busy_rd 0.
REQ-031 Reset mid-burst SHALL abandon the burst; remaining beats after release are ignored (state IDLE).

Structure
REQ-032 State encodings and FrameWords = FrameWidth*FrameHeight SHALL live in a shared package with the write controller's constants.
REQ-033 FIFO SHALL be sub-module pixel_fifo_sync (depth, width parameters; push, pop, full, empty, count).

Verification (FrameWidth=4, FrameHeight=2, BurstLengthSDRAM=4)
REQ-034 Release reset, i_pixel_req=0 -> rd_req addr 0, ack, 4 beats 0xA0..A3; second request addr 4; after its 4 beats no third request (FIFO full, 8).
REQ-035 Pop continuously -> pixels in beat order, o_sof with 0xA0 and again with 9th pixel; addresses 0,4,0,4.
REQ-036 Hold i_sdram_ack low 5 cycles -> rd_req and addr stable 5 cycles, no state advance.
REQ-037 Beats with gaps plus push+pop same cycle -> no loss/duplication, occupancy unchanged that cycle.
REQ-038 Assert RST low after beat 2 -> all outputs 0 asynchronously; stray beats after release ignored; next request addr 0.
REQ-039 i_pixel_req while empty -> no pop; first later pixel still carries o_sof.
